// File: rtl/track_pkg.sv
// Shared tracking definitions: FSM state type, frame/template defaults,
// score width and the saturating centre helper.
package track_pkg;

  localparam int SCORE_W_DEF    = 16;
  localparam int COORD_W        = 10;
  localparam int COORD_W1       = COORD_W + 1;
  localparam int FRAME_W_DEF    = 640;
  localparam int FRAME_H_DEF    = 480;
  localparam int TEMPLATE_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_SCAN    = 2'd2,
    ST_PUBLISH = 2'd3
  } state_e;

  // Template top-left plus centre offset, worked in 11 bits and clamped to lim-1.
  function automatic logic [COORD_W-1:0] sat_center(input logic [COORD_W-1:0] c,
                                                    input int ofs, input int lim);
    logic [COORD_W1-1:0] sum;
    sum = {1'b0, c} + COORD_W1'(ofs);
    if (sum > COORD_W1'(lim - 1)) return COORD_W'(lim - 1);
    return sum[COORD_W-1:0];
  endfunction

endpackage

// File: rtl/peak_locator_if.sv
// Score stream in / peak result out bundle between correlator, peak finder
// and box overlay.
// Handshake: no backpressure. score/score_x/score_y are meaningful only in a
// cycle with score_valid=1; frame_start/frame_end are single-cycle pulses;
// max_x/max_y/max_score/found are held and qualified by the one-cycle
// max_ready strobe.
interface peak_locator_if
  import track_pkg::*;
#(
  parameter int SCORE_W = SCORE_W_DEF
);
  logic                 frame_start;
  logic                 frame_end;
  logic                 score_valid;
  logic [SCORE_W-1:0]   score;
  logic [COORD_W-1:0]   score_x;
  logic [COORD_W-1:0]   score_y;
  logic [COORD_W-1:0]   max_x;
  logic [COORD_W-1:0]   max_y;
  logic [SCORE_W-1:0]   max_score;
  logic                 found;
  logic                 max_ready;

  modport master (
    output frame_start, frame_end, score_valid, score, score_x, score_y,
    input  max_x, max_y, max_score, found, max_ready
  );

  modport slave (
    input  frame_start, frame_end, score_valid, score, score_x, score_y,
    output max_x, max_y, max_score, found, max_ready
  );
endinterface

// File: rtl/peak_window_gate.sv
// Search gate around the previous peak: passes a candidate whose centre lies
// within WIN_RADIUS of the published peak on both axes. Only built with
// PEAK_WINDOW_EN defined.
`ifdef PEAK_WINDOW_EN
module peak_window_gate
  import track_pkg::*;
#(
  parameter int CENTER_OFS = TEMPLATE_WIDTH / 2,
  parameter int WIN_RADIUS = 32
) (
  input  logic [COORD_W-1:0] score_x,
  input  logic [COORD_W-1:0] score_y,
  input  logic [COORD_W-1:0] max_x,
  input  logic [COORD_W-1:0] max_y,
  output logic               in_gate
);
  // One spare bit beyond the 11-bit centre sum so the difference never wraps.
  logic [11:0] dx, dy, adx, ady;

  // Absolute centre-to-peak distance on each axis, then window compare.
  always_comb begin
    dx      = {2'b00, score_x} + 12'(CENTER_OFS) - {2'b00, max_x};
    dy      = {2'b00, score_y} + 12'(CENTER_OFS) - {2'b00, max_y};
    adx     = dx[11] ? (12'd0 - dx) : dx;
    ady     = dy[11] ? (12'd0 - dy) : dy;
    in_gate = (adx <= 12'(WIN_RADIUS)) && (ady <= 12'(WIN_RADIUS));
  end
endmodule
`endif

// File: rtl/peak_locator.sv
// Per-frame peak finder: tracks the best score over one frame and publishes
// its saturated centre with a one-cycle max_ready strobe.
// Build option: PEAK_WINDOW_EN restricts the search to a window around the
// previously published peak.
module peak_locator
  import track_pkg::*;
#(
  parameter int SCORE_W    = SCORE_W_DEF,
  parameter int FRAME_W    = FRAME_W_DEF,
  parameter int FRAME_H    = FRAME_H_DEF,
  parameter int CENTER_OFS = TEMPLATE_WIDTH / 2,
  parameter int WIN_RADIUS = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           tracking_mode,
  peak_locator_if.slave  bus,
  output state_e         state_dbg
);

  if (WIN_RADIUS < 0 || CENTER_OFS < 0) begin : g_bad_param
    $error("peak_locator: WIN_RADIUS and CENTER_OFS must be non-negative");
  end

  state_e               state_q, state_d;
  logic                 best_valid_q, best_valid_d;
  logic [SCORE_W-1:0]   best_score_q, best_score_d;
  logic [COORD_W-1:0]   best_x_q, best_x_d;
  logic [COORD_W-1:0]   best_y_q, best_y_d;
  logic [COORD_W-1:0]   max_x_q, max_x_d;
  logic [COORD_W-1:0]   max_y_q, max_y_d;
  logic [SCORE_W-1:0]   max_score_q, max_score_d;
  logic                 found_q, found_d;
  logic                 max_ready_q, max_ready_d;

  logic                 considered;
  logic                 accept;

`ifdef PEAK_WINDOW_EN
  logic in_gate;

  peak_window_gate #(
    .CENTER_OFS (CENTER_OFS),
    .WIN_RADIUS (WIN_RADIUS)
  ) u_gate (
    .score_x (bus.score_x),
    .score_y (bus.score_y),
    .max_x   (max_x_q),
    .max_y   (max_y_q),
    .in_gate (in_gate)
  );

  // Without a previous peak the whole frame is searched.
  assign considered = !found_q || in_gate;
`else
  assign considered = 1'b1;
`endif

  // Strictly greater wins, so ties keep the earlier raster position.
  assign accept = bus.score_valid && considered &&
                  (!best_valid_q || (bus.score > best_score_q));

  // Next-state, best-register and published-result computation.
  always_comb begin
    state_d      = state_q;
    best_valid_d = best_valid_q;
    best_score_d = best_score_q;
    best_x_d     = best_x_q;
    best_y_d     = best_y_q;
    max_x_d      = max_x_q;
    max_y_d      = max_y_q;
    max_score_d  = max_score_q;
    found_d      = found_q;
    max_ready_d  = 1'b0;

    if (!tracking_mode) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_WAIT;

        // PUBLISH is the strobe cycle; it behaves like WAIT so a frame may
        // start immediately after it.
        ST_WAIT, ST_PUBLISH: begin
          state_d = ST_WAIT;
          if (bus.frame_start) begin
            state_d      = ST_SCAN;
            best_valid_d = 1'b0;
            best_score_d = '0;
          end
        end

        ST_SCAN: begin
          if (bus.frame_start) begin
            // frame_end was missed: drop the partial result and rescan.
            best_valid_d = 1'b0;
            best_score_d = '0;
          end else begin
            if (accept) begin
              best_valid_d = 1'b1;
              best_score_d = bus.score;
              best_x_d     = bus.score_x;
              best_y_d     = bus.score_y;
            end
            if (bus.frame_end) begin
              // Result registered here so the strobe shows one cycle after
              // frame_end; a coincident score is already folded into *_d.
              state_d = ST_PUBLISH;
              if (best_valid_d) begin
                max_x_d     = sat_center(best_x_d, CENTER_OFS, FRAME_W);
                max_y_d     = sat_center(best_y_d, CENTER_OFS, FRAME_H);
                max_score_d = best_score_d;
                found_d     = 1'b1;
                max_ready_d = 1'b1;
              end else begin
                found_d     = 1'b0;
              end
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      best_valid_q <= 1'b0;
      best_score_q <= '0;
      best_x_q     <= '0;
      best_y_q     <= '0;
      max_x_q      <= COORD_W'(FRAME_W / 2);
      max_y_q      <= COORD_W'(FRAME_H / 2);
      max_score_q  <= '0;
      found_q      <= 1'b0;
      max_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      best_valid_q <= best_valid_d;
      best_score_q <= best_score_d;
      best_x_q     <= best_x_d;
      best_y_q     <= best_y_d;
      max_x_q      <= max_x_d;
      max_y_q      <= max_y_d;
      max_score_q  <= max_score_d;
      found_q      <= found_d;
      max_ready_q  <= max_ready_d;
    end
  end

  assign bus.max_x     = max_x_q;
  assign bus.max_y     = max_y_q;
  assign bus.max_score = max_score_q;
  assign bus.found     = found_q;
  assign bus.max_ready = max_ready_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_peak_locator.sv
// Bench for peak_locator: directed scenarios plus random frames checked
// against a frame-level peak model.
module tb_peak_locator;
  import track_pkg::*;

  localparam int SW = 16;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   tracking_mode = 1'b0;
  state_e state_dbg;

  peak_locator_if #(.SCORE_W(SW)) bus();

  peak_locator dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tracking_mode (tracking_mode),
    .bus           (bus.slave),
    .state_dbg     (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Scoreboard: expected published {max_x, max_y, max_score}.
  logic [2*COORD_W+SW-1:0] exp_q[$];

  // Reference view of the published outputs.
  int exp_x = 320, exp_y = 240, exp_score = 0;
  bit exp_found = 0;
  bit exp_pub   = 0;

  // Scores of the frame being driven.
  int fr_s[$], fr_x[$], fr_y[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // Peak of the frame = first maximum among considered scores; centre is
  // top-left + 16 clamped to the frame.
  task automatic model_publish();
    int best_i;
    int dx, dy;
    bit ok;
    best_i = -1;
    for (int i = 0; i < fr_s.size(); i++) begin
      ok = 1;
`ifdef PEAK_WINDOW_EN
      if (exp_found) begin
        dx = fr_x[i] + 16 - exp_x;
        dy = fr_y[i] + 16 - exp_y;
        if (dx < 0) dx = -dx;
        if (dy < 0) dy = -dy;
        ok = (dx <= 32) && (dy <= 32);
      end
`endif
      if (ok && (best_i < 0 || fr_s[i] > fr_s[best_i])) best_i = i;
    end
    if (best_i < 0) begin
      exp_found = 0;
      exp_pub   = 0;
    end else begin
      exp_x     = (fr_x[best_i] + 16 > 639) ? 639 : fr_x[best_i] + 16;
      exp_y     = (fr_y[best_i] + 16 > 479) ? 479 : fr_y[best_i] + 16;
      exp_score = fr_s[best_i];
      exp_found = 1;
      exp_pub   = 1;
      exp_q.push_back({COORD_W'(exp_x), COORD_W'(exp_y), SW'(exp_score)});
    end
  endtask

  // ---------------- driver ----------------
  task automatic idle_inputs();
    bus.frame_start = 0;
    bus.frame_end   = 0;
    bus.score_valid = 0;
    bus.score       = '0;
    bus.score_x     = '0;
    bus.score_y     = '0;
  endtask

  // Drives frame_start, the fr_* scores with random gaps, and frame_end
  // (optionally on the last score). Reports strobes seen inside the frame
  // and max_ready one and two cycles after frame_end.
  task automatic drive_frame(input bit fe_with_last, output int strobes_mid,
                             output bit rdy1, output bit rdy2);
    bit ended;
    strobes_mid = 0;
    ended = 0;
    bus.frame_start = 1;
    step();
    bus.frame_start = 0;
    if (bus.max_ready) strobes_mid++;
    for (int i = 0; i < fr_s.size(); i++) begin
      repeat ($urandom_range(0, 2)) begin
        step();
        if (bus.max_ready) strobes_mid++;
      end
      bus.score_valid = 1;
      bus.score       = SW'(fr_s[i]);
      bus.score_x     = COORD_W'(fr_x[i]);
      bus.score_y     = COORD_W'(fr_y[i]);
      if (fe_with_last && i == fr_s.size() - 1) begin
        bus.frame_end = 1;
        ended = 1;
      end
      step();
      bus.score_valid = 0;
      bus.frame_end   = 0;
      if (!ended && bus.max_ready) strobes_mid++;
    end
    if (!ended) begin
      bus.frame_end = 1;
      step();
      bus.frame_end = 0;
    end
    rdy1 = bus.max_ready;
    step();
    rdy2 = bus.max_ready;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int bad_strobe;
    idle_inputs();
    rst_n = 0;
    tracking_mode = 0;
    repeat (3) step();
    rst_n = 1;
    checks++;
    if (bus.max_x !== 10'd320 || bus.max_y !== 10'd240 || bus.max_score !== '0 ||
        bus.found !== 1'b0 || bus.max_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: got x=%0d y=%0d s=%0d f=%0b r=%0b required 320/240/0/0/0",
               bus.max_x, bus.max_y, bus.max_score, bus.found, bus.max_ready);
    end
    bad_strobe = 0;
    for (int i = 0; i < 1000; i++) begin
      if ((i % 97) == 0) begin
        bus.frame_start = 1'($urandom_range(0, 1));
        bus.frame_end   = 1'($urandom_range(0, 1));
      end else begin
        bus.frame_start = 0;
        bus.frame_end   = 0;
      end
      step();
      if (bus.max_ready !== 1'b0) bad_strobe++;
    end
    idle_inputs();
    checks++;
    if (bad_strobe != 0) begin
      failures++;
      $display("FAIL idle_no_strobe: got %0d strobes required 0", bad_strobe);
    end
    checks++;
    if (state_dbg !== ST_IDLE || bus.max_x !== 10'd320 || bus.found !== 1'b0) begin
      failures++;
      $display("FAIL idle_hold: got state=%0d x=%0d f=%0b required state=0 x=320 f=0",
               state_dbg, bus.max_x, bus.found);
    end
    exp_x = 320; exp_y = 240; exp_score = 0; exp_found = 0;
    tracking_mode = 1;
    step();
    step();
  endtask

  task automatic test_single_frame();
    int sm; bit r1, r2;
    logic [2*COORD_W+SW-1:0] e;
    fr_s = '{5, 9, 9}; fr_x = '{100, 200, 300}; fr_y = '{50, 80, 90};
    model_publish();
    drive_frame(0, sm, r1, r2);
    checks++;
    if (sm != 0 || r1 !== 1'b1 || r2 !== 1'b0) begin
      failures++;
      $display("FAIL single_strobe: got mid=%0d n1=%0b n2=%0b required 0/1/0", sm, r1, r2);
    end
    checks++;
    if (bus.max_x !== 10'd216 || bus.max_y !== 10'd96 || bus.max_score !== 16'd9 ||
        bus.found !== 1'b1) begin
      failures++;
      $display("FAIL single_result: got %0d,%0d s=%0d f=%0b required 216,96 s=9 f=1",
               bus.max_x, bus.max_y, bus.max_score, bus.found);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({bus.max_x, bus.max_y, bus.max_score} !== e) begin
        failures++;
        $display("FAIL single_scoreboard: got %h required %h",
                 {bus.max_x, bus.max_y, bus.max_score}, e);
      end
    end
  endtask

  task automatic test_window();
    int sm; bit r1, r2;
    fr_s = '{50, 20}; fr_x = '{400, 210}; fr_y = '{300, 90};
    model_publish();
    drive_frame(0, sm, r1, r2);
    void'(exp_q.pop_front());
    checks++;
    if (r1 !== exp_pub || r2 !== 1'b0 || sm != 0) begin
      failures++;
      $display("FAIL window_strobe: got n1=%0b n2=%0b mid=%0d required %0b/0/0", r1, r2, sm, exp_pub);
    end
    checks++;
    if (bus.max_x !== 10'(exp_x) || bus.max_y !== 10'(exp_y) ||
        bus.max_score !== 16'(exp_score) || bus.found !== exp_found) begin
      failures++;
      $display("FAIL window_result: got %0d,%0d s=%0d f=%0b required %0d,%0d s=%0d f=%0b",
               bus.max_x, bus.max_y, bus.max_score, bus.found, exp_x, exp_y, exp_score, exp_found);
    end
`ifdef PEAK_WINDOW_EN
    checks++;
    if (bus.max_x !== 10'd226 || bus.max_y !== 10'd106 || bus.max_score !== 16'd20) begin
      failures++;
      $display("FAIL window_gate: got %0d,%0d s=%0d required 226,106 s=20",
               bus.max_x, bus.max_y, bus.max_score);
    end
`endif
  endtask

  task automatic test_empty_frame();
    int sm; bit r1, r2;
    int px, py, ps;
    px = exp_x; py = exp_y; ps = exp_score;
    fr_s.delete(); fr_x.delete(); fr_y.delete();
    model_publish();
    drive_frame(0, sm, r1, r2);
    checks++;
    if (r1 !== 1'b0 || r2 !== 1'b0 || sm != 0) begin
      failures++;
      $display("FAIL empty_strobe: got n1=%0b n2=%0b mid=%0d required 0/0/0", r1, r2, sm);
    end
    checks++;
    if (bus.found !== 1'b0 || bus.max_x !== 10'(px) || bus.max_y !== 10'(py) ||
        bus.max_score !== 16'(ps)) begin
      failures++;
      $display("FAIL empty_hold: got %0d,%0d s=%0d f=%0b required %0d,%0d s=%0d f=0",
               bus.max_x, bus.max_y, bus.max_score, bus.found, px, py, ps);
    end
  endtask

  task automatic test_saturation();
    int sm; bit r1, r2;
    fr_s = '{3, 7}; fr_x = '{10, 630}; fr_y = '{10, 470};
    model_publish();
    drive_frame(1, sm, r1, r2);
    if (exp_pub) void'(exp_q.pop_front());
    checks++;
    if (r1 !== 1'b1 || r2 !== 1'b0 || sm != 0) begin
      failures++;
      $display("FAIL sat_strobe: got n1=%0b n2=%0b mid=%0d required 1/0/0", r1, r2, sm);
    end
    checks++;
    if (bus.max_x !== 10'd639 || bus.max_y !== 10'd479 || bus.max_score !== 16'd7 ||
        bus.found !== 1'b1) begin
      failures++;
      $display("FAIL sat_result: got %0d,%0d s=%0d f=%0b required 639,479 s=7 f=1",
               bus.max_x, bus.max_y, bus.max_score, bus.found);
    end
  endtask

  task automatic test_abort();
    int sm; bit r1, r2;
    int strobes;
    strobes = 0;
    // Frame abandoned by dropping tracking_mode.
    bus.frame_start = 1; step(); bus.frame_start = 0;
    bus.score_valid = 1; bus.score = 16'd100; bus.score_x = 10'd50; bus.score_y = 10'd50;
    step();
    bus.score_valid = 0;
    tracking_mode = 0;
    bus.frame_end = 1;
    step();
    bus.frame_end = 0;
    if (bus.max_ready) strobes++;
    checks++;
    if (state_dbg !== ST_IDLE) begin
      failures++;
      $display("FAIL abort_idle: got state=%0d required %0d", state_dbg, ST_IDLE);
    end
    step(); if (bus.max_ready) strobes++;
    tracking_mode = 1;
    step(); if (bus.max_ready) strobes++;
    // Frame abandoned by a repeated frame_start (inside drive_frame).
    bus.frame_start = 1; step(); bus.frame_start = 0;
    bus.score_valid = 1; bus.score = 16'd90; bus.score_x = 10'd1; bus.score_y = 10'd1;
    step(); if (bus.max_ready) strobes++;
    bus.score_valid = 0;
    fr_s = '{4}; fr_x = '{20}; fr_y = '{30};
    model_publish();
    drive_frame(0, sm, r1, r2);
    if (exp_pub) void'(exp_q.pop_front());
    checks++;
    if (strobes + sm != 0) begin
      failures++;
      $display("FAIL abort_no_strobe: got %0d strobes required 0", strobes + sm);
    end
    checks++;
    if (r1 !== exp_pub || bus.max_x !== 10'(exp_x) || bus.max_y !== 10'(exp_y) ||
        bus.max_score !== 16'(exp_score) || bus.found !== exp_found) begin
      failures++;
      $display("FAIL abort_result: got r=%0b %0d,%0d s=%0d f=%0b required r=%0b %0d,%0d s=%0d f=%0b",
               r1, bus.max_x, bus.max_y, bus.max_score, bus.found,
               exp_pub, exp_x, exp_y, exp_score, exp_found);
    end
  endtask

  task automatic test_random_frames();
    int sm; bit r1, r2;
    int n;
    logic [2*COORD_W+SW-1:0] e;
    for (int f = 0; f < 25; f++) begin
      fr_s.delete(); fr_x.delete(); fr_y.delete();
      n = $urandom_range(0, 6);
      for (int i = 0; i < n; i++) begin
        fr_s.push_back($urandom_range(0, 15));
        fr_x.push_back($urandom_range(0, 639));
        fr_y.push_back($urandom_range(0, 479));
      end
      model_publish();
      drive_frame(1'($urandom_range(0, 1)), sm, r1, r2);
      checks++;
      if (sm != 0 || r1 !== exp_pub || r2 !== 1'b0) begin
        failures++;
        $display("FAIL rand_strobe[%0d]: got mid=%0d n1=%0b n2=%0b required 0/%0b/0",
                 f, sm, r1, r2, exp_pub);
      end
      if (r1 === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rand_unexpected_pub[%0d]: got strobe required none", f);
        end else begin
          e = exp_q.pop_front();
          if ({bus.max_x, bus.max_y, bus.max_score} !== e) begin
            failures++;
            $display("FAIL rand_result[%0d]: got %h required %h", f,
                     {bus.max_x, bus.max_y, bus.max_score}, e);
          end
        end
      end
      checks++;
      if (bus.found !== exp_found) begin
        failures++;
        $display("FAIL rand_found[%0d]: got %0b required %0b", f, bus.found, exp_found);
      end
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid_frame();
    bus.frame_start = 1; step(); bus.frame_start = 0;
    bus.score_valid = 1; bus.score = 16'd500; bus.score_x = 10'd5; bus.score_y = 10'd5;
    step();
    rst_n = 0;
    bus.frame_end = 1;
    step();
    idle_inputs();
    checks++;
    if (bus.max_x !== 10'd320 || bus.max_y !== 10'd240 || bus.max_score !== '0 ||
        bus.found !== 1'b0 || bus.max_ready !== 1'b0 || state_dbg !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_mid: got %0d,%0d s=%0d f=%0b r=%0b st=%0d required 320,240 s=0 f=0 r=0 st=0",
               bus.max_x, bus.max_y, bus.max_score, bus.found, bus.max_ready, state_dbg);
    end
    rst_n = 1;
    step();
    checks++;
    if (bus.max_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_strobe: got %0b required 0", bus.max_ready);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle_inputs();
    test_reset();
    test_single_frame();
    test_window();
    test_empty_frame();
    test_saturation();
    test_abort();
    test_random_frames();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
